// File: rtl/rv32_exec_alu.sv
// Integer execute-stage ALU for the rv32 pipeline: RV32I arithmetic/logic/shift/SLT, address add, branch compare.
// Define ALU_OUT_REG_EN to register alu_result/zero/overflow (1-cycle latency); otherwise purely combinational.
module rv32_exec_alu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  func3,
  input  logic        alt,
  input  logic        force_add,
  input  logic        branch,
  input  logic [31:0] alu_a,
  input  logic [31:0] alu_b,
  output logic [31:0] alu_result,
  output logic        zero,
  output logic        overflow
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned SHW  = 5;

  logic [XLEN-1:0] sum_c;
  logic [XLEN-1:0] diff_c;
  logic            add_ovf_c;
  logic            sub_ovf_c;
  logic            lt_s_c;
  logic            lt_u_c;
  logic [SHW-1:0]  shamt_c;
  logic [XLEN-1:0] result_c;
  logic            zero_c;
  logic            ovf_c;

  // Shared adder/subtractor and comparators feed both normal and branch modes.
  assign sum_c     = alu_a + alu_b;
  assign diff_c    = alu_a - alu_b;
  assign add_ovf_c = (alu_a[XLEN-1] == alu_b[XLEN-1]) && (sum_c[XLEN-1]  != alu_a[XLEN-1]);
  assign sub_ovf_c = (alu_a[XLEN-1] != alu_b[XLEN-1]) && (diff_c[XLEN-1] != alu_a[XLEN-1]);
  assign lt_s_c    = $signed(alu_a) < $signed(alu_b);
  assign lt_u_c    = alu_a < alu_b;
  assign shamt_c   = alu_b[SHW-1:0];

  always_comb begin
    result_c = '0;
    zero_c   = 1'b0;
    ovf_c    = 1'b0;
    if (branch) begin
      // Compare outcome lands in bit 31 (and overflow) so LT/GE/LTU/GEU decode cheaply downstream.
      zero_c = (alu_a == alu_b);
      case (func3)
        3'b100, 3'b101: begin
          result_c = {lt_s_c, {(XLEN-1){1'b0}}};
          ovf_c    = lt_s_c;
        end
        3'b110, 3'b111: begin
          result_c = {lt_u_c, {(XLEN-1){1'b0}}};
          ovf_c    = lt_u_c;
        end
        default: result_c = diff_c;
      endcase
    end else begin
      if (force_add) begin
        result_c = sum_c;
        ovf_c    = add_ovf_c;
      end else begin
        case (func3)
          3'b000: begin
            result_c = alt ? diff_c : sum_c;
            ovf_c    = alt ? sub_ovf_c : add_ovf_c;
          end
          3'b001:  result_c = alu_a << shamt_c;
          3'b010:  result_c = {{(XLEN-1){1'b0}}, lt_s_c};
          3'b011:  result_c = {{(XLEN-1){1'b0}}, lt_u_c};
          3'b100:  result_c = alu_a ^ alu_b;
          3'b101:  result_c = alt ? XLEN'($signed(alu_a) >>> shamt_c) : (alu_a >> shamt_c);
          3'b110:  result_c = alu_a | alu_b;
          default: result_c = alu_a & alu_b;
        endcase
      end
      zero_c = (result_c == '0);
    end
  end

`ifdef ALU_OUT_REG_EN
  // Output stage; reset clears any in-flight result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_result <= '0;
      zero       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      alu_result <= result_c;
      zero       <= zero_c;
      overflow   <= ovf_c;
    end
  end
`else
  logic unused_clk_rst;
  assign unused_clk_rst = &{1'b0, clk, rst_n};

  assign alu_result = result_c;
  assign zero       = zero_c;
  assign overflow   = ovf_c;
`endif

endmodule

// File: tb/tb_rv32_exec_alu.sv
// Self-checking bench for rv32_exec_alu; works for both the combinational and ALU_OUT_REG_EN builds.
module tb_rv32_exec_alu;

  logic        clk;
  logic        rst_n;
  logic [2:0]  func3;
  logic        alt;
  logic        force_add;
  logic        branch;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_result;
  logic        zero;
  logic        overflow;

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic        o;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   checks;
  int   failures;

  rv32_exec_alu dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .func3      (func3),
    .alt        (alt),
    .force_add  (force_add),
    .branch     (branch),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .zero       (zero),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: overflow from 33-bit sign-extended arithmetic, shifts bit by bit.
  function automatic exp_t model(input logic [2:0] f3, input logic al, input logic fa,
                                 input logic br, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [32:0] w;
    logic [31:0] r;
    logic        cmp;
    int          sh;
    e.res = 32'h0;
    e.z   = 1'b0;
    e.o   = 1'b0;
    e.tag = "";
    sh    = int'(b[4:0]);
    if (br) begin
      e.z = (a == b);
      if (f3 == 3'b100 || f3 == 3'b101 || f3 == 3'b110 || f3 == 3'b111) begin
        if (f3[1]) cmp = (a < b);
        else       cmp = ($signed(a) < $signed(b));
        e.res = cmp ? 32'h8000_0000 : 32'h0;
        e.o   = cmp;
      end else begin
        e.res = a - b;
      end
    end else begin
      if (fa || (f3 == 3'b000 && !al)) begin
        w     = {a[31], a} + {b[31], b};
        e.res = w[31:0];
        e.o   = w[32] ^ w[31];
      end else if (f3 == 3'b000) begin
        w     = {a[31], a} - {b[31], b};
        e.res = w[31:0];
        e.o   = w[32] ^ w[31];
      end else begin
        case (f3)
          3'b001: begin
            r = a;
            for (int i = 0; i < sh; i++) r = {r[30:0], 1'b0};
            e.res = r;
          end
          3'b010: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          3'b011: e.res = (a < b) ? 32'd1 : 32'd0;
          3'b100: e.res = a ^ b;
          3'b101: begin
            r = a;
            for (int i = 0; i < sh; i++) r = {al ? r[31] : 1'b0, r[31:1]};
            e.res = r;
          end
          3'b110: e.res = a | b;
          default: e.res = a & b;
        endcase
      end
      e.z = (e.res == 32'h0);
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, act, exp);
    end
  endtask

  task automatic drive(input string tag, input logic [2:0] f3, input logic al, input logic fa,
                       input logic br, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    func3     = f3;
    alt       = al;
    force_add = fa;
    branch    = br;
    alu_a     = a;
    alu_b     = b;
    e         = model(f3, al, fa, br, a, b);
    e.tag     = tag;
    sb.push_back(e);
  endtask

  // One edge later is valid for both builds since inputs are held across it.
  task automatic check_out();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL scoreboard_empty: observed=0 entries expected=1");
    end else begin
      e = sb.pop_front();
      check({e.tag, "_res"}, alu_result, e.res);
      check({e.tag, "_zero"}, 32'(zero), 32'(e.z));
      check({e.tag, "_ovf"}, 32'(overflow), 32'(e.o));
    end
  endtask

  task automatic op(input string tag, input logic [2:0] f3, input logic al, input logic fa,
                    input logic br, input logic [31:0] a, input logic [31:0] b);
    drive(tag, f3, al, fa, br, a, b);
    check_out();
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    func3     = 3'b000;
    alt       = 1'b0;
    force_add = 1'b0;
    branch    = 1'b0;
    alu_a     = 32'h0;
    alu_b     = 32'h0;
    #2;
`ifdef ALU_OUT_REG_EN
    check("reset_res", alu_result, 32'h0);
    check("reset_zero", 32'(zero), 32'h0);
    check("reset_ovf", 32'(overflow), 32'h0);
`endif
    @(posedge clk);
    #3;
    rst_n = 1'b1;

    op("add_wrap",   3'b000, 1'b0, 1'b0, 1'b0, 32'h7FFF_FFFF, 32'h1);
    op("sub_zero",   3'b000, 1'b1, 1'b0, 1'b0, 32'd5, 32'd5);
    op("sub_ovf",    3'b000, 1'b1, 1'b0, 1'b0, 32'h8000_0000, 32'h1);
    op("sra_max",    3'b101, 1'b1, 1'b0, 1'b0, 32'h8000_0000, 32'h0000_003F);
    op("srl_max",    3'b101, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 32'h0000_003F);
    op("sll_31",     3'b001, 1'b0, 1'b0, 1'b0, 32'h1, 32'd31);
    op("sll_0",      3'b001, 1'b0, 1'b0, 1'b0, 32'hA5A5_0001, 32'hFFFF_FFE0);
    op("slt",        3'b010, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h1);
    op("sltu",       3'b011, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h1);
    op("xor",        3'b100, 1'b0, 1'b0, 1'b0, 32'hF0F0_1234, 32'h0FF0_1234);
    op("or",         3'b110, 1'b0, 1'b0, 1'b0, 32'h1200_0034, 32'h0056_7800);
    op("and_zero",   3'b111, 1'b0, 1'b0, 1'b0, 32'hF0F0_F0F0, 32'h0F0F_0F0F);
    op("br_lt",      3'b100, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE, 32'd2);
    op("br_ltu",     3'b110, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE, 32'd2);
    op("br_geu_t",   3'b111, 1'b0, 1'b0, 1'b1, 32'd2, 32'hFFFF_FFFE);
    op("br_eq",      3'b000, 1'b0, 1'b0, 1'b1, 32'd7, 32'd7);
    op("br_ne",      3'b001, 1'b1, 1'b1, 1'b1, 32'd9, 32'd7);
    op("br_undef",   3'b010, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 32'h1);
    op("force_add",  3'b111, 1'b1, 1'b1, 1'b0, 32'h0000_1000, 32'hFFFF_FFFC);

    for (int i = 0; i < 24; i++) begin
      op("rand", 3'($urandom_range(7)), 1'($urandom_range(1)), 1'($urandom_range(1)),
         1'($urandom_range(1)), $urandom, (i % 4 == 0) ? 32'h0 : $urandom);
    end

`ifdef ALU_OUT_REG_EN
    // Mid-stream reset: result in flight is dropped, outputs clear without a clock edge.
    func3 = 3'b110; alt = 1'b0; force_add = 1'b0; branch = 1'b0;
    alu_a = 32'h1234_0000; alu_b = 32'h0000_5678;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_res", alu_result, 32'h0);
    check("rst_mid_zero", 32'(zero), 32'h0);
    check("rst_mid_ovf", 32'(overflow), 32'h0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    drive("post_rst_add", 3'b000, 1'b0, 1'b0, 1'b0, 32'd3, 32'd4);
    #1;
    check("post_rst_pre_edge", alu_result, 32'h0);
    check_out();
`endif

    if (sb.size() != 0) begin
      checks++;
      failures++;
      $error("FAIL scoreboard_leftover: observed=%0d expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
